ddr4_cmd_sequencer: RTL and testbench

// Initiator side of the DDR4 DIMM interface: turns single-burst read/write requests into legal ACT/RD/WR/PRE

---
 rtl/ddr4_cmd_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 tb/tb_ddr4_cmd_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_cmd_sequencer.sv
// Closed-page DDR4 command sequencer: one read/write burst in flight, ACT -> RD|WR -> PRE timed
// from a single per-transaction cycle counter, with a write-burst serializer and read-burst deserializer on dq.
module ddr4_cmd_sequencer #(
  parameter int RANKS        = 1,
  parameter int BGWIDTH      = 2,
  parameter int BAWIDTH      = 2,
  parameter int ADDRWIDTH    = 17,
  parameter int COLWIDTH     = 10,
  parameter int DEVICE_WIDTH = 4,
  parameter int CHIPS        = 18,
  parameter int BL           = 8,
  parameter int TINIT        = 5,
  parameter int TRCD         = 15,
  parameter int TCL          = 15,
  parameter int TCWL         = 0,
  parameter int TRAS         = 36,
  parameter int TWR          = 16,
  parameter int TRP          = 15,
  localparam int DQWIDTH     = DEVICE_WIDTH * CHIPS,
  localparam int RKW         = (RANKS > 1) ? $clog2(RANKS) : 1
) (
  input  logic                    ck_t,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [RKW-1:0]          req_rank,
  input  logic [BGWIDTH-1:0]      req_bg,
  input  logic [BAWIDTH-1:0]      req_ba,
  input  logic [ADDRWIDTH-1:0]    req_row,
  input  logic [COLWIDTH-1:0]     req_col,
  input  logic [DQWIDTH*BL-1:0]   req_wdata,
  output logic [DQWIDTH*BL-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    cke,
  output logic                    odt,
  output logic                    parity,
  output logic [RANKS-1:0]        cs_n,
  output logic                    act_n,
  output logic [ADDRWIDTH-1:0]    A,
  output logic [BGWIDTH-1:0]      bg,
  output logic [BAWIDTH-1:0]      ba,
  output logic [DQWIDTH-1:0]      dq_out,
  output logic                    dq_oe,
  input  logic [DQWIDTH-1:0]      dq_in,
  output logic [CHIPS-1:0]        dqs_t_out,
  output logic [CHIPS-1:0]        dqs_c_out
);

  localparam int TW   = $clog2(TRCD + TCL + TCWL + TRAS + TWR + TRP + 2 * BL + 2) + 1;
  localparam int IW   = $clog2(TINIT + 1);
  localparam int BW   = (BL > 1) ? $clog2(BL) : 1;
  localparam int PWRI = (TRAS > TRCD + TCWL + BL + TWR) ? TRAS : (TRCD + TCWL + BL + TWR);
  localparam int PRDI = (TRAS > TRCD + 1) ? TRAS : (TRCD + 1);

  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [TW-1:0] T_CMD   = TW'(TRCD);
  localparam logic [TW-1:0] T_WR0   = TW'(TRCD + TCWL);
  localparam logic [TW-1:0] T_WRL   = TW'(TRCD + TCWL + BL - 1);
  localparam logic [TW-1:0] T_RD0   = TW'(TRCD + TCL);
  localparam logic [TW-1:0] T_RDL   = TW'(TRCD + TCL + BL - 1);
  localparam logic [TW-1:0] T_PWR   = TW'(PWRI);
  localparam logic [TW-1:0] T_PRD   = TW'(PRDI);
  localparam logic [TW-1:0] T_TRPM1 = TW'(TRP - 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(TINIT - 1);

  localparam logic [ADDRWIDTH-1:0] A_WR  = ADDRWIDTH'(17'h10000);
  localparam logic [ADDRWIDTH-1:0] A_RD  = ADDRWIDTH'(17'h14000);
  localparam logic [ADDRWIDTH-1:0] A_PRE = ADDRWIDTH'(17'h08000);

  localparam logic [3:0] S_INIT      = 4'd0;
  localparam logic [3:0] S_IDLE      = 4'd1;
  localparam logic [3:0] S_ACT       = 4'd2;
  localparam logic [3:0] S_TRCD_WAIT = 4'd3;
  localparam logic [3:0] S_CMD       = 4'd4;
  localparam logic [3:0] S_DATA      = 4'd5;
  localparam logic [3:0] S_PRE_WAIT  = 4'd6;
  localparam logic [3:0] S_PRE       = 4'd7;
  localparam logic [3:0] S_TRP_WAIT  = 4'd8;

  function automatic logic [RANKS-1:0] cs_decode(input logic [RKW-1:0] rank);
    cs_decode = ~(RANKS'(1) << rank);
  endfunction

  function automatic logic cmd_parity(input logic                 act_n_v,
                                      input logic [ADDRWIDTH-1:0] a_v,
                                      input logic [BGWIDTH-1:0]   bg_v,
                                      input logic [BAWIDTH-1:0]   ba_v);
    cmd_parity = ^{act_n_v, a_v, bg_v, ba_v};
  endfunction

  logic [3:0]              state_q, state_d;
  logic [IW-1:0]           init_cnt_q, init_cnt_d;
  logic [TW-1:0]           t_q, t_d;
  logic                    wr_q, wr_d;
  logic [RKW-1:0]          rank_q, rank_d;
  logic [BGWIDTH-1:0]      lat_bg_q, lat_bg_d;
  logic [BAWIDTH-1:0]      lat_ba_q, lat_ba_d;
  logic [COLWIDTH-1:0]     lat_col_q, lat_col_d;
  logic [DQWIDTH*BL-1:0]   wdata_q, wdata_d;

  logic                    cke_q, cke_d;
  logic                    odt_q, odt_d;
  logic                    parity_q, parity_d;
  logic [RANKS-1:0]        cs_n_q, cs_n_d;
  logic                    act_n_q, act_n_d;
  logic [ADDRWIDTH-1:0]    a_q, a_d;
  logic [BGWIDTH-1:0]      bg_q, bg_d;
  logic [BAWIDTH-1:0]      ba_q, ba_d;
  logic [DQWIDTH-1:0]      dq_out_q, dq_out_d;
  logic                    dq_oe_q, dq_oe_d;
  logic [CHIPS-1:0]        dqs_t_q, dqs_t_d;
  logic [CHIPS-1:0]        dqs_c_q, dqs_c_d;
  logic [DQWIDTH*BL-1:0]   rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;

  logic                    cmd_s;
  logic                    go_pre_s;
  logic                    busy_s;
  logic [TW-1:0]           p_sel_s;
  logic [BW-1:0]           wbeat_s;
  logic [BW-1:0]           rbeat_s;

  // Next-state and next-cycle pin values; every DIMM pin is registered from these.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    t_d        = t_q + T_ONE;
    wr_d       = wr_q;
    rank_d     = rank_q;
    lat_bg_d   = lat_bg_q;
    lat_ba_d   = lat_ba_q;
    lat_col_d  = lat_col_q;
    wdata_d    = wdata_q;
    cke_d      = cke_q;
    cs_n_d     = '1;
    act_n_d    = 1'b1;
    a_d        = '0;
    bg_d       = '0;
    ba_d       = '0;
    cmd_s      = 1'b0;
    go_pre_s   = 1'b0;
    odt_d      = 1'b0;
    dq_oe_d    = 1'b0;
    dq_out_d   = '0;
    dqs_t_d    = '0;
    dqs_c_d    = '0;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    busy_s     = (state_q != S_INIT) && (state_q != S_IDLE);
    p_sel_s    = wr_q ? T_PWR : T_PRD;
    wbeat_s    = BW'(t_d - T_WR0);
    rbeat_s    = BW'(t_q - T_RD0);

    case (state_q)
      S_INIT: begin
        cke_d = 1'b1;
        t_d   = '0;
        if (init_cnt_q == INIT_LAST) begin
          state_d = S_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + IW'(1);
        end
      end
      S_IDLE: begin
        t_d = '0;
        if (req_valid) begin
          state_d   = S_ACT;
          wr_d      = req_write;
          rank_d    = req_rank;
          lat_bg_d  = req_bg;
          lat_ba_d  = req_ba;
          lat_col_d = req_col;
          wdata_d   = req_wdata;
          cs_n_d    = cs_decode(req_rank);
          act_n_d   = 1'b0;
          a_d       = req_row;
          bg_d      = req_bg;
          ba_d      = req_ba;
          cmd_s     = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACT, S_TRCD_WAIT: begin
        if (t_d == T_CMD) begin
          state_d = S_CMD;
          cs_n_d  = cs_decode(rank_q);
          a_d     = (wr_q ? A_WR : A_RD) | ADDRWIDTH'(lat_col_q);
          bg_d    = lat_bg_q;
          ba_d    = lat_ba_q;
          cmd_s   = 1'b1;
        end else begin
          state_d = S_TRCD_WAIT;
        end
      end
      S_CMD: begin
        state_d = S_DATA;
      end
      S_DATA: begin
        // Reads only gate PRE by the read-to-precharge spacing; the burst keeps arriving after PRE.
        if (!wr_q || (t_q >= T_WRL)) begin
          if (t_d >= p_sel_s) begin
            go_pre_s = 1'b1;
          end else begin
            state_d = S_PRE_WAIT;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PRE_WAIT: begin
        if (t_d >= p_sel_s) begin
          go_pre_s = 1'b1;
        end else begin
          state_d = S_PRE_WAIT;
        end
      end
      S_PRE, S_TRP_WAIT: begin
        // IDLE one cycle early so an accepted request's ACT lands exactly TRP after PRE.
        if (t_d >= p_sel_s + T_TRPM1) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_TRP_WAIT;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase

    if (go_pre_s) begin
      state_d = S_PRE;
      cs_n_d  = cs_decode(rank_q);
      a_d     = A_PRE;
      bg_d    = lat_bg_q;
      ba_d    = lat_ba_q;
      cmd_s   = 1'b1;
    end else begin
      cmd_s = cmd_s;
    end

    if (busy_s && wr_q && (t_d >= T_WR0) && (t_d <= T_WRL)) begin
      dq_oe_d  = 1'b1;
      odt_d    = 1'b1;
      dqs_t_d  = '1;
      dqs_c_d  = '0;
      dq_out_d = wdata_q[32'(wbeat_s) * DQWIDTH +: DQWIDTH];
    end else begin
      dq_oe_d = 1'b0;
    end

    if (busy_s && !wr_q && (t_q >= T_RD0) && (t_q <= T_RDL)) begin
      rd_data_d[32'(rbeat_s) * DQWIDTH +: DQWIDTH] = dq_in;
      rd_valid_d = (t_q == T_RDL);
    end else begin
      rd_valid_d = 1'b0;
    end

    parity_d = cmd_s ? cmd_parity(act_n_d, a_d, bg_d, ba_d) : 1'b0;
  end

  // State, latched request and registered DIMM pins.
  always_ff @(posedge ck_t or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      t_q        <= '0;
      wr_q       <= 1'b0;
      rank_q     <= '0;
      lat_bg_q   <= '0;
      lat_ba_q   <= '0;
      lat_col_q  <= '0;
      wdata_q    <= '0;
      cke_q      <= 1'b0;
      odt_q      <= 1'b0;
      parity_q   <= 1'b0;
      cs_n_q     <= '1;
      act_n_q    <= 1'b1;
      a_q        <= '0;
      bg_q       <= '0;
      ba_q       <= '0;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      dqs_t_q    <= '0;
      dqs_c_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      t_q        <= t_d;
      wr_q       <= wr_d;
      rank_q     <= rank_d;
      lat_bg_q   <= lat_bg_d;
      lat_ba_q   <= lat_ba_d;
      lat_col_q  <= lat_col_d;
      wdata_q    <= wdata_d;
      cke_q      <= cke_d;
      odt_q      <= odt_d;
      parity_q   <= parity_d;
      cs_n_q     <= cs_n_d;
      act_n_q    <= act_n_d;
      a_q        <= a_d;
      bg_q       <= bg_d;
      ba_q       <= ba_d;
      dq_out_q   <= dq_out_d;
      dq_oe_q    <= dq_oe_d;
      dqs_t_q    <= dqs_t_d;
      dqs_c_q    <= dqs_c_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign cke       = cke_q;
  assign odt       = odt_q;
  assign parity    = parity_q;
  assign cs_n      = cs_n_q;
  assign act_n     = act_n_q;
  assign A         = a_q;
  assign bg        = bg_q;
  assign ba        = ba_q;
  assign dq_out    = dq_out_q;
  assign dq_oe     = dq_oe_q;
  assign dqs_t_out = dqs_t_q;
  assign dqs_c_out = dqs_c_q;

endmodule

// File: tb/tb_ddr4_cmd_sequencer.sv
// Directed bench for ddr4_cmd_sequencer: vector table of single transactions plus
// hand-written reset, back-to-back and mid-burst-reset sequences.
module tb_ddr4_cmd_sequencer;
  localparam int DQW = 72;
  localparam int BLN = 8;

  typedef struct {
    logic        wr;
    logic [1:0]  bgv;
    logic [1:0]  bav;
    logic [16:0] row;
    logic [9:0]  col;
    logic [31:0] seed;
    logic [16:0] exp_act_a;
    logic [16:0] exp_cmd_a;
    int          exp_pre;
    int          exp_rdv;
  } vec_t;

  logic             ck_t = 1'b0;
  logic             reset_n;
  logic             req_valid, req_ready, req_write;
  logic [0:0]       req_rank;
  logic [1:0]       req_bg, req_ba;
  logic [16:0]      req_row;
  logic [9:0]       req_col;
  logic [DQW*BLN-1:0] req_wdata, rd_data;
  logic             rd_valid, cke, odt, parity, act_n, dq_oe;
  logic [0:0]       cs_n;
  logic [16:0]      A;
  logic [1:0]       bg, ba;
  logic [DQW-1:0]   dq_out, dq_in;
  logic [17:0]      dqs_t_out, dqs_c_out;

  int checks = 0;
  int errors = 0;
  vec_t vecs[4];

  ddr4_cmd_sequencer dut (
    .ck_t(ck_t), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_rank(req_rank), .req_bg(req_bg), .req_ba(req_ba),
    .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata), .rd_data(rd_data),
    .rd_valid(rd_valid), .cke(cke), .odt(odt), .parity(parity), .cs_n(cs_n), .act_n(act_n),
    .A(A), .bg(bg), .ba(ba), .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in),
    .dqs_t_out(dqs_t_out), .dqs_c_out(dqs_c_out)
  );

  always #5 ck_t = ~ck_t;

  task automatic chk(input string name, input logic [DQW*BLN-1:0] got, input logic [DQW*BLN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [DQW-1:0] beat(input logic [31:0] seed, input int k);
    logic [7:0] kb;
    kb = 8'(k);
    return {kb, seed, ~seed};
  endfunction

  function automatic logic [DQW*BLN-1:0] burst(input logic [31:0] seed);
    logic [DQW*BLN-1:0] b;
    for (int k = 0; k < BLN; k++) b[k*DQW +: DQW] = beat(seed, k);
    return b;
  endfunction

  // Command-bus parity and odt/dq_oe agreement on every cycle out of reset.
  always @(negedge ck_t) begin
    if (reset_n === 1'b1) begin
      if (cs_n !== 1'b1) chk("parity_cmd", ^{act_n, A, bg, ba, parity}, 0);
      else chk("parity_deselect", parity, 0);
      chk("odt_vs_oe", odt, dq_oe);
    end
  end

  task automatic wait_ready(input string tag);
    int w = 0;
    while (req_ready !== 1'b1 && w < 100) begin
      @(negedge ck_t);
      w++;
    end
    chk({tag, "_ready"}, req_ready, 1);
  endtask

  task automatic run_txn(input vec_t v, input string tag, input int abort_cyc);
    int n_act = 0, n_cmd = 0, n_pre = 0, n_oe = 0, bad_oe = 0, n_rdv = 0;
    int act_cyc = -1, cmd_cyc = -1, pre_cyc = -1, rdv_cyc = -1, idx;
    logic [16:0] act_a = '0, cmd_a = '0, pre_a = '0;
    logic [3:0]  act_bb = '0, cmd_bb = '0, pre_bb = '0;
    logic [DQW*BLN-1:0] rdv_data = '0;
    wait_ready(tag);
    req_valid = 1'b1; req_write = v.wr; req_rank = 1'b0; req_bg = v.bgv; req_ba = v.bav;
    req_row = v.row; req_col = v.col; req_wdata = burst(v.seed);
    @(negedge ck_t);
    req_valid = 1'b0; req_write = ~v.wr; req_bg = ~v.bgv; req_ba = ~v.bav;
    req_row = ~v.row; req_col = ~v.col; req_wdata = '0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (cyc == abort_cyc) begin
        chk({tag, "_oe_before_reset"}, dq_oe, 1);
        chk({tag, "_beat3_before_reset"}, dq_out, beat(v.seed, 3));
        reset_n = 1'b0;
        #1;
        chk({tag, "_oe_async_clear"}, dq_oe, 0);
        chk({tag, "_csn_async_clear"}, cs_n, 1);
        return;
      end
      if (cs_n == 1'b0 && act_n == 1'b0) begin
        n_act++; act_cyc = cyc; act_a = A; act_bb = {bg, ba};
      end else if (cs_n == 1'b0 && A[16]) begin
        n_cmd++; cmd_cyc = cyc; cmd_a = A; cmd_bb = {bg, ba};
      end else if (cs_n == 1'b0) begin
        n_pre++; pre_cyc = cyc; pre_a = A; pre_bb = {bg, ba};
      end
      if (dq_oe) begin
        n_oe++;
        idx = (cmd_cyc >= 0) ? cyc - cmd_cyc : -1;
        if (idx < 0 || idx > 7) bad_oe++;
        else if (dq_out !== beat(v.seed, idx)) bad_oe++;
        if (dqs_t_out !== '1 || dqs_c_out !== '0) bad_oe++;
      end
      if (rd_valid) begin
        n_rdv++; rdv_cyc = cyc; rdv_data = rd_data;
      end
      if (!v.wr && cmd_cyc >= 0 && cyc - cmd_cyc >= 15 && cyc - cmd_cyc <= 22)
        dq_in = beat(v.seed, cyc - cmd_cyc - 15);
      else
        dq_in = {9{8'hE7}};
      @(negedge ck_t);
    end
    chk({tag, "_act_count"}, n_act, 1);
    chk({tag, "_act_cycle"}, act_cyc, 0);
    chk({tag, "_act_addr"}, act_a, v.exp_act_a);
    chk({tag, "_act_bgba"}, act_bb, {v.bgv, v.bav});
    chk({tag, "_cmd_count"}, n_cmd, 1);
    chk({tag, "_cmd_cycle"}, cmd_cyc, 15);
    chk({tag, "_cmd_addr"}, cmd_a, v.exp_cmd_a);
    chk({tag, "_cmd_bgba"}, cmd_bb, {v.bgv, v.bav});
    chk({tag, "_pre_count"}, n_pre, 1);
    chk({tag, "_pre_cycle"}, pre_cyc, v.exp_pre);
    chk({tag, "_pre_addr"}, pre_a, 17'h08000);
    chk({tag, "_pre_bgba"}, pre_bb, {v.bgv, v.bav});
    if (v.wr) begin
      chk({tag, "_oe_beats"}, n_oe, 8);
      chk({tag, "_beat_errors"}, bad_oe, 0);
      chk({tag, "_no_rd_valid"}, n_rdv, 0);
    end else begin
      chk({tag, "_no_oe"}, n_oe, 0);
      chk({tag, "_rdv_count"}, n_rdv, 1);
      chk({tag, "_rdv_cycle"}, rdv_cyc, v.exp_rdv);
      chk({tag, "_rd_data"}, rdv_data, burst(v.seed));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acts[4];
    int pres[4];
    int na, np;
    vecs[0] = '{1'b1, 2'd1, 2'd1, 17'h00001, 10'h000, 32'hA5A50001, 17'h00001, 17'h10000, 39, -1};
    vecs[1] = '{1'b0, 2'd1, 2'd1, 17'h00001, 10'h000, 32'h5A5A0002, 17'h00001, 17'h14000, 36, 38};
    vecs[2] = '{1'b1, 2'd2, 2'd3, 17'h1ABCD, 10'h2A5, 32'h12345678, 17'h1ABCD, 17'h102A5, 39, -1};
    vecs[3] = '{1'b0, 2'd0, 2'd2, 17'h0F0F0, 10'h3FF, 32'hCAFEF00D, 17'h0F0F0, 17'h143FF, 36, 38};

    reset_n = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_rank = 1'b0; req_bg = '0; req_ba = '0;
    req_row = '0; req_col = '0; req_wdata = '0; dq_in = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge ck_t);
    chk("rst_cke", cke, 0);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_act_n", act_n, 1);
    chk("rst_A", A, 0);
    chk("rst_bgba", {bg, ba}, 0);
    chk("rst_odt_par", {odt, parity}, 0);
    chk("rst_dq", {dq_oe, dq_out}, 0);
    chk("rst_dqs", {dqs_t_out, dqs_c_out}, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rd", {rd_valid, rd_data}, 0);
    reset_n = 1'b1;
    #1 chk("cke_before_edge", cke, 0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge ck_t);
      chk("cke_after_release", cke, 1);
      chk("init_deselect", cs_n, 1);
      chk("init_ready", req_ready, (i == 5) ? 1 : 0);
    end

    for (int i = 0; i < 4; i++) run_txn(vecs[i], $sformatf("vec%0d", i), -1);

    // Back-to-back writes with req_valid held high throughout.
    wait_ready("b2b");
    req_valid = 1'b1; req_write = 1'b1; req_bg = 2'd3; req_ba = 2'd0; req_row = 17'h00042;
    req_col = 10'h010; req_wdata = burst(32'h0BB0BB00);
    na = 0; np = 0;
    for (int cyc = 0; cyc < 130; cyc++) begin
      if (cs_n == 1'b0 && act_n == 1'b0 && na < 4) begin acts[na] = cyc; na++; end
      else if (cs_n == 1'b0 && !A[16] && np < 4) begin pres[np] = cyc; np++; end
      @(negedge ck_t);
    end
    req_valid = 1'b0;
    chk("b2b_act_count", na, 3);
    chk("b2b_pre_count", np, 2);
    chk("b2b_gap1", (na > 1 && np > 0) ? acts[1] - pres[0] : -1, 15);
    chk("b2b_gap2", (na > 2 && np > 1) ? acts[2] - pres[1] : -1, 15);
    repeat (60) @(negedge ck_t);

    // Reset asserted during write beat 3 (cycle a+18), then recovery.
    run_txn(vecs[0], "abort", 18);
    for (int i = 0; i < 3; i++) begin
      @(negedge ck_t);
      chk("abort_no_pre", cs_n, 1);
      chk("abort_oe_low", dq_oe, 0);
    end
    reset_n = 1'b1;
    run_txn(vecs[2], "recover", -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
